wave_display_multi: RTL and testbench



---
 rtl/wave_display_multi.sv | 173 +++++++++++++++++
 tb/tb_wave_display_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wave_display_multi.sv
// Multi-channel waveform renderer: maps (x, y) into per-channel sample RAM reads and draws
// connected traces, two pipeline stages deep. Define WAVE_GRID_EN to add a background grid.
module wave_display_multi #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 9,
  parameter int X_START  = 256,
  parameter int Y_START  = 0,
  parameter logic [NUM_CH*24-1:0] CH_COLORS = {24'h00FF00, 24'hFFFFFF}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*SAMPLE_W-1:0]   read_value,
  output logic [ADDR_W-1:0]            read_address,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  localparam int COL_W = ADDR_W - 1;
  localparam logic [11:0] X_LO   = 12'(X_START);
  localparam logic [11:0] X_HI   = 12'(X_START + (1 << ADDR_W));
  localparam logic [10:0] X_LO11 = 11'(X_START);
  localparam logic [10:0] Y_LO   = 11'(Y_START);
  localparam logic [10:0] Y_HI   = 11'(Y_START + (1 << (SAMPLE_W + 1)));
  localparam logic [9:0]  Y_LO10 = 10'(Y_START);

  // Offset binary with the sign bit kept: largest positive sample maps to code 0 (top row).
  function automatic logic [SAMPLE_W-1:0] to_code(input logic signed [SAMPLE_W-1:0] s);
    return {s[SAMPLE_W-1], ~s[SAMPLE_W-2:0]};
  endfunction

  logic               in_x;
  logic               in_y;
  logic               in_win;
  logic [COL_W-1:0]   col;
  logic [SAMPLE_W-1:0] row;
  logic               idx_q;

  // ---- stage 0: window test and RAM address ----
  always_comb begin
    in_x   = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI);
    in_y   = ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    in_win = valid && in_x && in_y;
    col    = in_x ? COL_W'((x - X_LO11) >> 1) : '0;
    row    = in_y ? SAMPLE_W'((y - Y_LO10) >> 1) : '0;
  end

  assign read_address = {idx_q, col};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= 1'b0;
    end else if (valid && (x == 11'd0) && (y == 10'd0)) begin
      idx_q <= read_index;
    end
  end

  // ---- stage 1: sample arrives, trace state and hit test ----
  logic                vld_p1;
  logic                in_win_p1;
  logic [COL_W-1:0]    col_p1;
  logic [SAMPLE_W-1:0] row_p1;
`ifdef WAVE_GRID_EN
  logic [5:0]          gx_p1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      in_win_p1 <= 1'b0;
    end else begin
      vld_p1    <= valid;
      in_win_p1 <= in_win;
    end
  end

  always_ff @(posedge clk) begin
    col_p1 <= col;
    row_p1 <= row;
`ifdef WAVE_GRID_EN
    gx_p1  <= 6'(x - X_LO11);
`endif
  end

  logic [SAMPLE_W-1:0] cur_s  [NUM_CH];
  logic [SAMPLE_W-1:0] prev_s [NUM_CH];
  logic [SAMPLE_W-1:0] code   [NUM_CH];
  logic [SAMPLE_W-1:0] cur_n  [NUM_CH];
  logic [SAMPLE_W-1:0] prev_n [NUM_CH];
  logic [COL_W-1:0]    last_col;
  logic                was_in;
  logic                upd;
  logic [NUM_CH-1:0]   hit;
  logic [SAMPLE_W-1:0] lo;
  logic [SAMPLE_W-1:0] hi;

  always_comb begin
    upd = in_win_p1 && (!was_in || (col_p1 != last_col));
    hit = '0;
    lo  = '0;
    hi  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      code[c]   = to_code($signed(read_value[c*SAMPLE_W +: SAMPLE_W]));
      // Column 0 restarts the trace so it does not join the previous scanline's last sample.
      prev_n[c] = upd ? ((col_p1 == '0) ? code[c] : cur_s[c]) : prev_s[c];
      cur_n[c]  = upd ? code[c] : cur_s[c];
      lo        = (prev_n[c] < code[c]) ? prev_n[c] : code[c];
      hi        = (prev_n[c] < code[c]) ? code[c] : prev_n[c];
      hit[c]    = ch_en[c] && in_win_p1 && (row_p1 >= lo) && (row_p1 <= hi);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cur_s[c]  <= '0;
        prev_s[c] <= '0;
      end
      was_in   <= 1'b0;
      last_col <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cur_s[c]  <= cur_n[c];
        prev_s[c] <= prev_n[c];
      end
      if (in_win_p1) begin
        was_in   <= 1'b1;
        last_col <= col_p1;
      end else if (vld_p1) begin
        was_in   <= 1'b0;
      end
    end
  end

  // ---- stage 2: colour select and registered outputs ----
  logic        pix_n;
  logic [23:0] rgb_n;

  always_comb begin
    pix_n = |hit;
    rgb_n = 24'h000000;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit[c]) rgb_n = CH_COLORS[c*24 +: 24];
    end
`ifdef WAVE_GRID_EN
    if (!pix_n && in_win_p1 &&
        ((row_p1 == SAMPLE_W'(1 << (SAMPLE_W - 1))) || (gx_p1 == 6'd0))) begin
      pix_n = 1'b1;
      rgb_n = 24'h404040;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pixel <= 1'b0;
      r           <= 8'd0;
      g           <= 8'd0;
      b           <= 8'd0;
    end else begin
      valid_pixel <= pix_n;
      {r, g, b}   <= rgb_n;
    end
  end

endmodule

// File: tb/tb_wave_display_multi.sv
// Directed bench for wave_display_multi with default parameters and a 1-cycle-latency RAM model.
module tb_wave_display_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [1:0]  ch_en;
  logic [15:0] read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;

  logic [7:0]  mem0 [512];
  logic [7:0]  mem1 [512];

  int n_chk  = 0;
  int n_pass = 0;

  wave_display_multi dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .valid        (valid),
    .read_index   (read_index),
    .ch_en        (ch_en),
    .read_value   (read_value),
    .read_address (read_address),
    .valid_pixel  (valid_pixel),
    .r            (r),
    .g            (g),
    .b            (b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) read_value <= {mem1[read_address], mem0[read_address]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_px(input int px, input int py, input logic pv);
    @(negedge clk);
    x     = 11'(px);
    y     = 10'(py);
    valid = pv;
  endtask

  task automatic scan(input int x0, input int x1, input int py);
    for (int i = x0; i <= x1; i++) set_px(i, py, 1'b1);
  endtask

  task automatic wait2();
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] rgb();
    return {8'd0, r, g, b};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem0[i] = 8'h35;
      mem1[i] = 8'h80;
    end
    reset = 1'b1; x = '0; y = '0; valid = 1'b0; read_index = 1'b0; ch_en = 2'b11;
    repeat (2) @(negedge clk);
    check("reset_vp", 32'(valid_pixel), 32'd0);
    check("reset_rgb", rgb(), 32'h0);
    check("reset_addr", 32'(read_address), 32'd0);
    reset = 1'b0;

    // trace visible before reset, then asynchronous clear
    set_px(300, 148, 1'b1);
    wait2();
    check("pre_rst_vp", 32'(valid_pixel), 32'd1);
    check("pre_rst_rgb", rgb(), 32'hFFFFFF);
    #2 reset = 1'b1;
    y = 10'd100;
    #1;
    check("async_rst_vp", 32'(valid_pixel), 32'd0);
    check("async_rst_rgb", rgb(), 32'h0);
    check("async_rst_addr", 32'(read_address), 32'd22);
    y = 10'd148;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_hold", 32'(valid_pixel), 32'd0);
    @(negedge clk);
    check("post_rst_recover", 32'(valid_pixel), 32'd1);

    // out of window
    set_px(9, 69, 1'b1);
    #1 check("oow_addr", 32'(read_address), 32'd0);
    wait2();
    check("oow_vp", 32'(valid_pixel), 32'd0);
    check("oow_rgb", rgb(), 32'h0);

    // flat trace: ch0 code 74, ch1 code 255
    scan(256, 265, 148);
    #1 check("flat_addr", 32'(read_address), 32'd4);
    wait2();
    check("flat_y148_vp", 32'(valid_pixel), 32'd1);
    check("flat_y148_rgb", rgb(), 32'hFFFFFF);
    set_px(265, 149, 1'b1);
    wait2();
    check("flat_y149_vp", 32'(valid_pixel), 32'd1);
    check("flat_y149_rgb", rgb(), 32'hFFFFFF);
    set_px(265, 150, 1'b1);
    wait2();
    check("flat_y150_vp", 32'(valid_pixel), 32'd0);
    set_px(265, 510, 1'b1);
    wait2();
    check("flat_ch1_rgb", rgb(), 32'h00FF00);

    // segment col4 code 74 -> col5 code 202
    mem0[5] = 8'hB5;
    scan(256, 266, 300);
    wait2();
    check("seg_x266_vp", 32'(valid_pixel), 32'd1);
    check("seg_x266_rgb", rgb(), 32'hFFFFFF);
    scan(256, 264, 300);
    wait2();
    check("seg_x264_vp", 32'(valid_pixel), 32'd0);

    // column 0 after leaving the window is a single point at code 0
    mem0[0] = 8'h7F;
    set_px(9, 2, 1'b1);
    set_px(256, 2, 1'b1);
    wait2();
    check("col0_row1_vp", 32'(valid_pixel), 32'd0);
    set_px(256, 0, 1'b1);
    wait2();
    check("col0_row0_rgb", rgb(), 32'hFFFFFF);
    mem0[0] = 8'h35;

    // priority and enables: both channels at code 74
    for (int i = 0; i < 512; i++) mem1[i] = 8'h35;
    scan(256, 265, 148);
    wait2();
    check("prio_rgb", rgb(), 32'hFFFFFF);
    ch_en = 2'b10;
    wait2();
    check("en10_rgb", rgb(), 32'h00FF00);
    ch_en = 2'b00;
    wait2();
    check("en00_vp", 32'(valid_pixel), 32'd0);
    check("en00_rgb", rgb(), 32'h0);
    ch_en = 2'b11;

    // not-valid pixel inside the window: no hit and trace state untouched
    set_px(266, 300, 1'b0);
    wait2();
    check("nv_vp", 32'(valid_pixel), 32'd0);
    set_px(265, 300, 1'b1);
    wait2();
    check("nv_prev_kept", 32'(valid_pixel), 32'd0);

    // buffer index latches only at a valid (0,0)
    set_px(265, 200, 1'b1);
    read_index = 1'b1;
    #1 check("idx_mid_addr", 32'(read_address), 32'd4);
    set_px(300, 201, 1'b1);
    #1 check("idx_mid2_addr", 32'(read_address), 32'd22);
    set_px(0, 0, 1'b0);
    #1 check("idx_nv00_addr", 32'(read_address), 32'd0);
    set_px(0, 0, 1'b1);
    #1 check("idx_00_addr", 32'(read_address), 32'd0);
    set_px(265, 0, 1'b1);
    #1 check("idx_new_addr", 32'(read_address), 32'd260);

    // grid column at x=256, row 200, no trace there
    set_px(256, 400, 1'b1);
    wait2();
`ifdef WAVE_GRID_EN
    check("grid_vp", 32'(valid_pixel), 32'd1);
    check("grid_rgb", rgb(), 32'h404040);
`else
    check("nogrid_vp", 32'(valid_pixel), 32'd0);
    check("nogrid_rgb", rgb(), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
